// File: rtl/demux_1x8_buffered_pkg.sv
// demux_1x8_buffered_pkg: shared sizes and buffer state encoding for the 1:8 demux
package demux_1x8_buffered_pkg;
  localparam int SEL_W = 3;
  localparam int N_PORTS = 2 ** SEL_W;
  localparam int DROP_CNT_W = 8;
  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } state_e;
endpackage

// File: rtl/demux_1x8_buffered_skid_buffer_2.sv
// demux_1x8_buffered_skid_buffer_2: 2-entry valid/ready buffer; in_ready comes from state only
module demux_1x8_buffered_skid_buffer_2
  import demux_1x8_buffered_pkg::*;
#(
  parameter int W = 35
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] in_data,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] out_data
);
  state_e state_q, state_d;
  logic [W-1:0] main_q, main_d, skid_q, skid_d;
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= EMPTY;
      main_q  <= '0;
      skid_q  <= '0;
    end else begin
      state_q <= state_d;
      main_q  <= main_d;
      skid_q  <= skid_d;
    end
  end
  always_comb begin
    state_d = state_q;
    main_d  = main_q;
    skid_d  = skid_q;
    case (state_q)
      EMPTY: begin
        if (in_valid) begin
          state_d = ONE;
          main_d  = in_data;
        end
      end
      ONE: begin
        if (in_valid && out_ready) begin
          main_d = in_data;
        end else if (in_valid) begin
          state_d = FULL;
          skid_d  = in_data;
        end else if (out_ready) begin
          state_d = EMPTY;
        end
      end
      FULL: begin
        if (out_ready) begin
          state_d = ONE;
          main_d  = skid_q;
        end
      end
      default: state_d = EMPTY;
    endcase
  end
  // main_q is left untouched on drain so out_data keeps its last value in EMPTY
  assign in_ready  = state_q != FULL;
  assign out_valid = state_q != EMPTY;
  assign out_data  = main_q;
endmodule

// File: rtl/demux_1x8_buffered.sv
// demux_1x8_buffered: buffered 1:8 word router with masked-port drop counting
module demux_1x8_buffered
  import demux_1x8_buffered_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int SEL_W = demux_1x8_buffered_pkg::SEL_W,
  parameter logic [2**SEL_W-1:0] PORT_MASK = '1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [SEL_W-1:0]      in_sel,
  input  logic [DATA_W-1:0]     in_data,
  output logic [2**SEL_W-1:0]   out_valid,
  input  logic [2**SEL_W-1:0]   out_ready,
  output logic [DATA_W-1:0]     out_data,
  output logic [SEL_W-1:0]      out_sel,
  output logic                  drop_pulse,
  output logic [DROP_CNT_W-1:0] drop_count
);
  localparam int NP = 2 ** SEL_W;
  logic en, store_valid, main_valid, drop_pulse_d, drop_pulse_q;
  logic [DROP_CNT_W-1:0] drop_count_d, drop_count_q;
  logic [SEL_W+DATA_W-1:0] main_word;
  always_comb begin
    en           = PORT_MASK[in_sel];
    store_valid  = in_valid & en;
    drop_pulse_d = in_valid & in_ready & ~en;
    drop_count_d = (drop_pulse_d && drop_count_q != '1) ? drop_count_q + DROP_CNT_W'(1) : drop_count_q;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      drop_pulse_q <= 1'b0;
      drop_count_q <= '0;
    end else begin
      drop_pulse_q <= drop_pulse_d;
      drop_count_q <= drop_count_d;
    end
  end
  demux_1x8_buffered_skid_buffer_2 #(.W(SEL_W + DATA_W)) u_buf (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (store_valid),
    .in_ready  (in_ready),
    .in_data   ({in_sel, in_data}),
    .out_valid (main_valid),
    .out_ready (out_ready[out_sel]),
    .out_data  (main_word)
  );
  assign out_sel    = main_word[SEL_W+DATA_W-1:DATA_W];
  assign out_data   = main_word[DATA_W-1:0];
  assign out_valid  = main_valid ? NP'(NP'(1) << out_sel) : '0;
  assign drop_pulse = drop_pulse_q;
  assign drop_count = drop_count_q;
endmodule

// File: tb/tb_demux_1x8_buffered.sv
// tb_demux_1x8_buffered: directed stimulus with a FIFO scoreboard checked by a monitor
module tb_demux_1x8_buffered;
  import demux_1x8_buffered_pkg::*;
  localparam logic [N_PORTS-1:0] PM = 8'h7F;
  typedef struct packed {
    logic [SEL_W-1:0] sel;
    logic [31:0]      data;
  } item_t;
  logic clk = 0, rst = 1, in_valid = 0, in_ready, drop_pulse;
  logic [SEL_W-1:0] in_sel = '0, out_sel;
  logic [31:0] in_data = '0, out_data;
  logic [N_PORTS-1:0] out_valid, out_ready = '1;
  logic [7:0] drop_count;
  int checks = 0, errors = 0, exp_cnt = 0;
  bit drop_pend = 0, streaming = 0;
  item_t exp_q[$];
  item_t it;

  demux_1x8_buffered #(.DATA_W(32), .SEL_W(SEL_W), .PORT_MASK(PM)) dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_sel     (in_sel),
    .in_data    (in_data),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_data   (out_data),
    .out_sel    (out_sel),
    .drop_pulse (drop_pulse),
    .drop_count (drop_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  // monitor: compares against the FIFO model, then records this cycle's accept
  initial forever begin
    @(negedge clk);
    if (rst) begin
      exp_q.delete();
      drop_pend = 0;
      exp_cnt = 0;
    end else begin
      chk("drop_pulse", 64'(drop_pulse), 64'(drop_pend));
      chk("drop_count", 64'(drop_count), 64'(exp_cnt));
      chk("out_valid_any", 64'(out_valid != 0), 64'(exp_q.size() != 0));
      chk("in_ready_model", 64'(in_ready), 64'(exp_q.size() < 2));
      if (streaming) chk("stream_in_ready", 64'(in_ready), 64'd1);
      if (exp_q.size() != 0) begin
        it = exp_q[0];
        chk("out_valid_onehot", 64'(out_valid), 64'(8'(8'd1 << it.sel)));
        chk("out_sel", 64'(out_sel), 64'(it.sel));
        chk("out_data", 64'(out_data), 64'(it.data));
        if (out_ready[it.sel]) void'(exp_q.pop_front());
      end
      drop_pend = in_valid && in_ready && !PM[in_sel];
      if (drop_pend && exp_cnt < 255) exp_cnt++;
      if (in_valid && in_ready && PM[in_sel]) exp_q.push_back({in_sel, in_data});
    end
  end

  // called at posedge+1; returns at posedge+1 just after the accepting edge
  task automatic send(input logic [SEL_W-1:0] s, input logic [31:0] d);
    int w = 0;
    in_valid = 1;
    in_sel = s;
    in_data = d;
    @(negedge clk);
    while (!in_ready && w < 50) begin
      w++;
      @(negedge clk);
    end
    if (!in_ready) chk("in_ready_timeout", 64'd0, 64'd1);
    @(posedge clk);
    #1 in_valid = 0;
  endtask

  task automatic do_reset();
    rst = 1;
    @(posedge clk);
    #1 rst = 0;
  endtask

  initial begin
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_out_data", 64'(out_data), 64'd0);
    chk("rst_out_sel", 64'(out_sel), 64'd0);
    chk("rst_in_ready", 64'(in_ready), 64'd1);
    chk("rst_drop_pulse", 64'(drop_pulse), 64'd0);
    chk("rst_drop_count", 64'(drop_count), 64'd0);
    @(posedge clk);
    #1 rst = 0;
    // single word, one-cycle latency
    send(3, 32'hDEADBEEF);
    @(negedge clk);
    chk("t1_out_valid", 64'(out_valid), 64'h08);
    chk("t1_out_data", 64'(out_data), 64'hDEADBEEF);
    @(negedge clk);
    chk("t1_out_valid_after", 64'(out_valid), 64'h00);
    @(posedge clk);
    #1 out_ready = '0;
    // backpressure fills both entries
    send(0, 32'h11);
    send(5, 32'h22);
    @(negedge clk);
    chk("t2_in_ready_full", 64'(in_ready), 64'd0);
    @(posedge clk);
    #1 out_ready = '1;
    @(negedge clk);
    chk("t2_first_valid", 64'(out_valid), 64'h01);
    chk("t2_first_data", 64'(out_data), 64'h11);
    @(negedge clk);
    chk("t2_second_valid", 64'(out_valid), 64'h20);
    chk("t2_second_data", 64'(out_data), 64'h22);
    @(negedge clk);
    chk("t2_empty", 64'(out_valid), 64'h00);
    @(posedge clk);
    #1 streaming = 1;
    for (int i = 0; i < 16; i++) send(SEL_W'(i % 8), 32'h100 + 32'(i));
    streaming = 0;
    // word on port 0 held while only other ports are ready
    repeat (3) @(negedge clk);
    @(posedge clk);
    #1 out_ready = 8'hFE;
    send(0, 32'hCAFE0001);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("t6_hold_valid", 64'(out_valid), 64'h01);
      chk("t6_hold_data", 64'(out_data), 64'hCAFE0001);
    end
    @(posedge clk);
    #1 out_ready = '1;
    @(negedge clk);
    @(negedge clk);
    chk("t6_drained", 64'(out_valid), 64'h00);
    @(posedge clk);
    #1 do_reset();
    send(7, 32'h0BAD0BAD);
    @(negedge clk);
    chk("t4_drop_pulse", 64'(drop_pulse), 64'd1);
    chk("t4_drop_count", 64'(drop_count), 64'd1);
    chk("t4_no_valid", 64'(out_valid), 64'h00);
    @(negedge clk);
    chk("t4_pulse_low", 64'(drop_pulse), 64'd0);
    @(posedge clk);
    #1;
    for (int i = 0; i < 300; i++) send(7, 32'(i));
    @(negedge clk);
    chk("t4_saturated", 64'(drop_count), 64'hFF);
    @(posedge clk);
    #1 out_ready = '0;
    // reset while FULL discards both held words
    send(1, 32'hA1);
    send(2, 32'hA2);
    @(negedge clk);
    chk("t5_full", 64'(in_ready), 64'd0);
    @(posedge clk);
    #1 do_reset();
    @(negedge clk);
    chk("t5_out_valid", 64'(out_valid), 64'h00);
    chk("t5_in_ready", 64'(in_ready), 64'd1);
    @(posedge clk);
    #1 out_ready = '1;
    begin
      int w = 0;
      while (exp_q.size() != 0 && w < 20) begin
        w++;
        @(negedge clk);
      end
      if (exp_q.size() != 0) chk("drain_timeout", 64'(exp_q.size()), 64'd0);
    end
    repeat (3) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
